mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shares the single unified 16-bit memory between the IF-stage instruction fetch port and the MEM-stage data port of the pipelined CPU. Each access is a one-word transaction with a variable-latency memory handshake, and the data port wins any conflict by default. The block generates per-port stall signals for the pipeline control. A timeout protects against a memory that never acknowledges; a timed-out fetch returns 16'h0000 (NOP).

Parameters:
DATA_W, 16, word width of data and instructions
ADDR_W, 16, address width
TIMEOUT, 15, max WAIT cycles before abort; legal range 1..255

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
i_req  in  1  fetch request; held high until i_ack is seen
i_addr  in  ADDR_W  fetch address; stable while i_req is high
i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid
i_rdata  out  DATA_W  fetched instruction
i_stall  out  1  i_req & ~i_ack (combinational)
d_req  in  1  data request; held high until d_ack is seen
d_wr  in  1  1=write, 0=read; qualified by d_req
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_ack  out  1  one-cycle pulse: data access complete
d_rdata  out  DATA_W  read data; 0 for writes
d_stall  out  1  d_req & ~d_ack (combinational)
mem_en  out  1  one-cycle command strobe to memory
mem_wr  out  1  write qualifier for mem_en
mem_addr  out  ADDR_W  latched command address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  memory read data; valid with mem_ack
mem_ack  in  1  memory completion pulse
err  out  1  sticky: at least one timeout since reset

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Reset value is IDLE.
- Outputs on reset: i_ack, d_ack, mem_en, mem_wr and err are 0. i_rdata, d_rdata, mem_addr and mem_wdata are 0. The owner flag is cleared and the timeout counter is 0.
- IDLE:
  - d_req=1: owner=D; latch d_addr, d_wdata and d_wr; go to ISSUE.
  - Otherwise i_req=1: owner=I; latch i_addr; mem_wr=0; go to ISSUE.
  - Neither: stay in IDLE.
- ISSUE: mem_en=1 for exactly this cycle, timeout counter set to 0.
  - mem_ack=1 in this cycle: capture mem_rdata and go to RESP.
  - Otherwise go to WAIT.
- WAIT: mem_en=0; counter increments each cycle.
  - mem_ack=1: capture mem_rdata and go to RESP.
  - Counter reaches TIMEOUT with no ack: abort; captured data forced to 0; err set to 1; go to RESP.
- RESP: the owner's ack is 1 for exactly one cycle and its rdata holds the captured data; then go to IDLE.
  - Requests are ignored in RESP, so the requester has one cycle to drop its req.
  - For writes, d_rdata is 0.
- rdata registers hold their value until the next RESP for the same port.
- Latency: minimum 2 cycles from req sampled in IDLE to ack (mem_ack in ISSUE). Back-to-back transactions start at most every 3 cycles.
- mem_ack arriving in IDLE or RESP is ignored. A mem_ack arriving after an abort is also ignored.
- Simultaneous i_req and d_req in IDLE: D is granted. I stays stalled and is granted at the next IDLE if still requested.
- Requests are never preempted: a D request arriving during an I transaction waits for that transaction to finish.
- Reset mid-transaction: on the next edge, return to IDLE, drop mem_en and acks, and clear err. A pending mem_ack is not forwarded.
- Address and data are passed through unchanged; the block performs no arithmetic beyond the timeout counter (8 bits, saturating, never wraps).

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin priority. When both ports request in IDLE, the port that did NOT own the last completed transaction wins. Reset state favours D. A single requester is always granted.
- Undefined: fixed D-over-I priority as described in Behaviour.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2, ST_RESP=2'd3
  - owner codes OWN_I=1'b0, OWN_D=1'b1
  - NOP word 16'h0000, shared with the hazard and flush logic
- One sub-module is natural: mem_arb_timer (8-bit clear/enable/saturating counter with a terminal-count output compare against TIMEOUT).

Test Plan:
- i_req=1, i_addr=16'h0040; memory acks in ISSUE with mem_rdata=16'hA123 -> mem_en pulse in cycle 1, mem_addr=16'h0040, i_ack in cycle 2, i_rdata=16'hA123, i_stall high in cycles 0-1.
- i_req and d_req both high, d_wr=1, d_addr=16'h1000, d_wdata=16'h5555 -> first command has mem_wr=1 and mem_addr=16'h1000; d_ack precedes i_ack; the I command issues 3 cycles after the D command. With MEM_ARB_RR_EN defined and last owner D, I goes first instead.
- d_req read; mem_ack withheld -> abort after TIMEOUT=15 WAIT cycles; d_ack=1, d_rdata=16'h0000, err=1 and sticky; a late mem_ack is ignored.
- mem_ack 4 cycles after mem_en on a fetch -> i_ack exactly one cycle after mem_ack; no second mem_en while i_req is held during RESP.
- rst_n=0 during WAIT -> next cycle: state IDLE, mem_en=0, acks=0, err=0; a mem_ack in the following cycle produces no ack.
- Spurious mem_ack in IDLE with no requests -> no ack, no state change, rdata unchanged.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants for the unified-memory arbiter.
//   ST_*     : FSM state encoding (IDLE, ISSUE, WAIT, RESP)
//   OWN_*    : owner codes for the port holding the memory
//   NOP_WORD : all-zero instruction word, also used by hazard/flush logic
package mem_arbiter_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam logic [15:0] NOP_WORD = 16'h0000;

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: 8-bit saturating wait counter with terminal-count compare.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : force count to 0 (wins over en)
//   en         : count one cycle of waiting
//   tc         : this enabled cycle is the TIMEOUT-th one
module mem_arb_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [7:0] cnt;
   logic [7:0] cnt_inc;

   // saturate at 8'hFF so the count can never wrap back to a small value
   assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

   // tc looks at the incremented value so the abort lands in the same
   // cycle the count reaches TIMEOUT
   assign tc = en && (cnt_inc == 8'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (!rst_n)   cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt_inc;
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory between the fetch (i_*) and data (d_*) ports.
//   i_req/i_addr -> i_ack/i_rdata/i_stall      : instruction fetch port
//   d_req/d_wr/d_addr/d_wdata -> d_ack/d_rdata/d_stall : data port
//   mem_en/mem_wr/mem_addr/mem_wdata, mem_rdata/mem_ack : memory handshake
//   err : sticky, set on any memory timeout since reset
// Build option: MEM_ARB_RR_EN selects round-robin priority when both ports
// request together; without it the data port always wins.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_stall,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_stall,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              err
);

   logic [1:0]        state;
   logic              owner;
   logic              wr_q;
   logic              grant_d;
   logic              tmr_tc;
   logic              done;
   logic              abort;
   logic [DATA_W-1:0] cap_data;

`ifdef MEM_ARB_RR_EN
   // owner of the last completed transaction; resets to I so D is favoured
   logic last_own;

   always_ff @(posedge clk) begin
      if (!rst_n)                 last_own <= OWN_I;
      else if (state == ST_RESP)  last_own <= owner;
   end

   assign grant_d = d_req && (!i_req || last_own == OWN_I);
`else
   assign grant_d = d_req;
`endif

   mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state == ST_ISSUE),
      .en    (state == ST_WAIT),
      .tc    (tmr_tc)
   );

   // mem_ack only counts while a command is outstanding; ack beats timeout
   // when both happen in the same WAIT cycle
   always_comb begin
      done     = ((state == ST_ISSUE) && mem_ack) ||
                 ((state == ST_WAIT)  && (mem_ack || tmr_tc));
      abort    = (state == ST_WAIT) && !mem_ack && tmr_tc;
      cap_data = mem_ack ? mem_rdata : DATA_W'(NOP_WORD);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         owner     <= OWN_I;
         wr_q      <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (d_req || i_req) begin
                  state <= ST_ISSUE;
                  if (grant_d) begin
                     owner     <= OWN_D;
                     wr_q      <= d_wr;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                  end else begin
                     owner    <= OWN_I;
                     wr_q     <= 1'b0;
                     mem_addr <= i_addr;
                  end
               end
            end
            ST_ISSUE, ST_WAIT: state <= done ? ST_RESP : ST_WAIT;
            default:           state <= ST_IDLE;  // RESP: requests ignored
         endcase

         // each port's rdata changes only when that port's response is formed
         if (done) begin
            if (owner == OWN_D) d_rdata <= wr_q ? DATA_W'(NOP_WORD) : cap_data;
            else                i_rdata <= cap_data;
         end

         if (abort) err <= 1'b1;
      end
   end

   assign mem_en  = (state == ST_ISSUE);
   assign mem_wr  = wr_q;
   assign i_ack   = (state == ST_RESP) && (owner == OWN_I);
   assign d_ack   = (state == ST_RESP) && (owner == OWN_D);
   assign i_stall = i_req & ~i_ack;
   assign d_stall = d_req & ~d_ack;

endmodule
